// File: rtl/zdet_pkg.sv
// zdet_pkg
// Shared constants and types for the zero-detect arbiter.
//   ZD_W       width of the single zero-detect datapath
//   ZD_OPW     width of a wide operand (two detector passes)
//   zd_state_e sequencer states: idle/arbitrate, low-word pass, high-word pass
package zdet_pkg;

  localparam int ZD_W   = 32;
  localparam int ZD_OPW = 64;

  typedef enum logic [1:0] {
    ZS_IDLE = 2'd0,
    ZS_LO   = 2'd1,
    ZS_HI   = 2'd2
  } zd_state_e;

endpackage

// File: rtl/zero_detect32.sv
// zero_detect32
// Purely combinational all-zero detect on one detector-width word.
// Ports:
//   a_i  in  ZD_W  word under test
//   q_o  out 1     1 when every bit of a_i is 0
module zero_detect32
  import zdet_pkg::*;
(
  input  logic [ZD_W-1:0] a_i,
  output logic            q_o
);

  assign q_o = ~|a_i;

endmodule

// File: rtl/zdet_arb.sv
// zdet_arb
// Round-robin arbiter and sequencer sharing one 32-bit zero detector among
// NREQ requesters. Narrow requests test op[31:0] in one pass; wide requests
// test op[63:0] over two passes, holding the low-word result in between.
// Ports:
//   sys_clk  in  1        clock, rising edge
//   reset    in  1        synchronous active-high reset
//   req      in  NREQ     request levels, sampled only while idle
//   wide     in  NREQ     64-bit mode select, captured at grant
//   data     in  NREQ*64  operands, requester i at [64i+63:64i]
//   gnt      out NREQ     one-hot grant pulse
//   busy     out 1        high while a transaction is in the detector
//   done     out 1        result-valid pulse
//   done_id  out IDW      requester whose result is on zero
//   zero     out 1        operand-is-zero result, held until the next done
module zdet_arb
  import zdet_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        wide,
  input  logic [NREQ*ZD_OPW-1:0] data,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
  output logic                   done,
  output logic [IDW-1:0]         done_id,
  output logic                   zero
);

  zd_state_e          state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     cur_id_q, cur_id_d;
  logic               cur_wide_q, cur_wide_d;
  logic [ZD_OPW-1:0]  op_q, op_d;
  logic               z_lo_q, z_lo_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [IDW-1:0]     done_id_q, done_id_d;
  logic               zero_q, zero_d;

  // Per-requester operand view of the packed data bus.
  logic [ZD_OPW-1:0]  data_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign data_arr[gi] = data[gi*ZD_OPW +: ZD_OPW];
    end
  endgenerate

  // The single detector sees the low word except during the high-word pass.
  logic [ZD_W-1:0] zd_in;
  logic            zd_q;

  assign zd_in = (state_q == ZS_HI) ? op_q[ZD_OPW-1:ZD_W] : op_q[ZD_W-1:0];

  zero_detect32 u_zd (
    .a_i (zd_in),
    .q_o (zd_q)
  );

  // Round-robin pick: first set req bit scanning upward from rr_ptr, wrapping
  // at NREQ-1 (explicit so non-power-of-two NREQ never selects a ghost slot).
  logic           win_found;
  logic [IDW-1:0] win_id;
  int             idx;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cur_id_d   = cur_id_q;
    cur_wide_d = cur_wide_q;
    op_d       = op_q;
    z_lo_d     = z_lo_q;
    gnt_d      = '0;
    done_d     = 1'b0;
    done_id_d  = done_id_q;
    zero_d     = zero_q;

    case (state_q)
      ZS_IDLE: begin
        if (win_found) begin
          cur_id_d      = win_id;
          cur_wide_d    = wide[win_id];
          op_d          = data_arr[win_id];
          gnt_d[win_id] = 1'b1;
          rr_ptr_d      = (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
          state_d       = ZS_LO;
        end
      end
      ZS_LO: begin
        if (!cur_wide_q) begin
          done_d    = 1'b1;
          zero_d    = zd_q;
          done_id_d = cur_id_q;
          state_d   = ZS_IDLE;
        end else begin
          z_lo_d  = zd_q;
          state_d = ZS_HI;
        end
      end
      ZS_HI: begin
        done_d    = 1'b1;
        zero_d    = z_lo_q & zd_q;
        done_id_d = cur_id_q;
        state_d   = ZS_IDLE;
      end
      default: state_d = ZS_IDLE;
    endcase

    // busy is registered alongside the state so it tracks "not idle" exactly.
    busy_d = (state_d != ZS_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= ZS_IDLE;
      rr_ptr_q   <= '0;
      cur_id_q   <= '0;
      cur_wide_q <= 1'b0;
      op_q       <= '0;
      z_lo_q     <= 1'b0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_id_q   <= cur_id_d;
      cur_wide_q <= cur_wide_d;
      op_q       <= op_d;
      z_lo_q     <= z_lo_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      zero_q     <= zero_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign zero    = zero_q;

endmodule

// File: tb/tb_zdet_arb.sv
// tb_zdet_arb
// Self-checking bench for zdet_arb: directed scenarios followed by random
// traffic, all compared cycle by cycle against a transaction-level model
// (arbitrate when free, result due one or two cycles later).
module tb_zdet_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                sys_clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     wide;
  logic [NREQ*64-1:0]  data;
  logic [NREQ-1:0]     gnt;
  logic                busy;
  logic                done;
  logic [IDW-1:0]      done_id;
  logic                zero;

  always #5 sys_clk = ~sys_clk;

  zdet_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .req     (req),
    .wide    (wide),
    .data    (data),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .zero    (zero)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: cycles left until the in-flight result is due (0 = free),
  // next-priority requester, and the last reported result.
  int  m_rem  = 0;
  int  m_rr   = 0;
  int  m_id   = 0;
  bit  m_zero = 1'b0;
  int  t_id   = 0;
  bit  t_zero = 1'b0;
  int  grants[$];
  int  busy_cycles = 0;

  // Applies the current inputs at one rising edge and checks every output.
  task automatic step();
    logic [NREQ-1:0]    sreq, swide, exp_gnt;
    logic [NREQ*64-1:0] sdata;
    logic [63:0]        op;
    logic               srst, exp_done, exp_busy;
    int                 w;
    sreq  = req;
    swide = wide;
    sdata = data;
    srst  = reset;
    @(posedge sys_clk);
    #1;
    exp_gnt  = '0;
    exp_done = 1'b0;
    w        = -1;
    if (srst) begin
      m_rem  = 0;
      m_rr   = 0;
      m_id   = 0;
      m_zero = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        exp_done = 1'b1;
        m_id     = t_id;
        m_zero   = t_zero;
      end
    end else if (sreq != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && sreq[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
      end
      op      = sdata[w*64 +: 64];
      t_id    = w;
      t_zero  = swide[w] ? (op == 64'd0) : (op[31:0] == 32'd0);
      m_rem   = swide[w] ? 2 : 1;
      m_rr    = (w + 1) % NREQ;
      exp_gnt = NREQ'(1) << w;
      grants.push_back(w);
    end
    exp_busy = (m_rem > 0);
    if (busy) busy_cycles++;
    check("gnt",     64'(gnt),     64'(exp_gnt));
    check("done",    64'(done),    64'(exp_done));
    check("busy",    64'(busy),    64'(exp_busy));
    check("done_id", 64'(done_id), 64'(m_id));
    check("zero",    64'(zero),    64'(m_zero));
    if (exp_done) $display("txn id=%0d zero=%0b", m_id, m_zero);
  endtask

  task automatic set_slice(input int i, input logic [31:0] hi, input logic [31:0] lo);
    data[i*64 +: 64] = {hi, lo};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // One transaction from a single requester that drops req in its gnt cycle.
  task automatic one_txn(input int i, input bit w, input logic [31:0] hi, input logic [31:0] lo);
    req     = '0;
    wide    = '0;
    req[i]  = 1'b1;
    wide[i] = w;
    set_slice(i, hi, lo);
    step();
    req = '0;
    step();
    if (w) step();
    step();
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    wide  = '0;
    data  = '0;
    do_reset();

    // Narrow zero; busy for the single detector pass only.
    busy_cycles = 0;
    one_txn(0, 1'b0, 32'h0, 32'h0);
    check("narrow_busy_cycles", 64'(busy_cycles), 64'd1);

    // Narrow: upper word must be ignored.
    one_txn(2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    check("narrow_nz_zero", 64'(zero), 64'd0);
    one_txn(2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);
    check("narrow_hi_ignored", 64'(zero), 64'd1);

    // Wide operands.
    busy_cycles = 0;
    one_txn(3, 1'b1, 32'h0000_0001, 32'h0000_0000);
    check("wide_hi_bit_zero", 64'(zero), 64'd0);
    check("wide_busy_cycles", 64'(busy_cycles), 64'd2);
    one_txn(3, 1'b1, 32'h0, 32'h0);
    check("wide_all_zero", 64'(zero), 64'd1);
    one_txn(3, 1'b1, 32'h0, 32'h8000_0000);
    check("wide_lo_bit_zero", 64'(zero), 64'd0);

    // Round-robin from a fresh pointer with everyone requesting.
    do_reset();
    grants.delete();
    req  = '1;
    wide = '0;
    data = '0;
    for (int c = 0; c < 12; c++) step();
    req = '0;
    step();
    check("rr_count", 64'(grants.size()), 64'd6);
    for (int g = 0; g < 6 && g < grants.size(); g++)
      check("rr_order", 64'(grants[g]), 64'(g % NREQ));

    // Operand is captured at grant; later bus changes must not matter.
    req  = 4'b0001;
    wide = '0;
    set_slice(0, 32'h0, 32'h0);
    step();
    req = '0;
    set_slice(0, 32'h0, 32'hDEAD_BEEF);
    step();
    check("capture_zero", 64'(zero), 64'd1);
    step();

    // Reset during the high-word pass abandons the transaction.
    req  = 4'b0100;
    wide = 4'b0100;
    set_slice(2, 32'h0, 32'h0);
    step();
    req = '0;
    step();
    reset = 1'b1;
    step();
    check("rst_no_done", 64'(done), 64'd0);
    reset = 1'b0;
    grants.delete();
    req = '1;
    step();
    check("rst_rr_grant", 64'(gnt), 64'd1);
    req = '0;
    step();
    step();

    // Random traffic, including occasional mid-operation resets.
    for (int c = 0; c < 500; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      req   = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      wide  = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        set_slice(i,
                  ($urandom_range(0, 1) == 0) ? 32'h0 : (32'h1 << $urandom_range(0, 31)),
                  ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom);
      end
      step();
    end
    reset = 1'b0;
    req   = '0;
    step();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
